// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Show-ahead result buffer between the single-cycle ALU and a slower
//   consumer. Each entry is {result[31:0], negative, overflow, zero}.
//   The ALU side is never stalled. A push into a full FIFO without a
//   same-cycle pop is dropped, and drop_err latches until reset or clear.
//
// Parameters
//   DEPTH         number of entries (power of two, >= 2)
//   AFULL_THRESH  almost-full level, 1..DEPTH-1 (used only with the macro)
//
// Ports
//   CLK, nRST                clock (rising edge), async active-low reset
//   clear                    synchronous flush; overrides push and pop
//   push, push_*             capture strobe and ALU result/flags
//   push_ready               FIFO not full
//   pop                      consumer takes the head entry
//   pop_valid, pop_*         FIFO not empty; head entry (zero when empty)
//   count                    occupancy, 0..DEPTH
//   drop_err                 sticky lost-push indicator
//   almost_full              registered, next count >= AFULL_THRESH
//                            (present only when ALU_FIFO_AFULL_EN is defined)
//
// Build option: define ALU_FIFO_AFULL_EN to add the almost_full output.
module alu_result_fifo #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   clear,
  input  logic                   push,
  input  logic [31:0]            push_result,
  input  logic                   push_negative,
  input  logic                   push_overflow,
  input  logic                   push_zero,
  output logic                   push_ready,
  input  logic                   pop,
  output logic                   pop_valid,
  output logic [31:0]            pop_result,
  output logic                   pop_negative,
  output logic                   pop_overflow,
  output logic                   pop_zero,
  output logic [$clog2(DEPTH):0] count,
`ifdef ALU_FIFO_AFULL_EN
  output logic                   almost_full,
`endif
  output logic                   drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH >= DEPTH) begin : g_bad_thresh
    $error("alu_result_fifo: AFULL_THRESH must be in 1..DEPTH-1");
  end

  logic [34:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic          w_full, w_empty, w_pop_acc, w_push_acc, w_push_lost;
  logic [CW-1:0] w_cnt_nxt;
  logic [34:0]   w_head;

  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign w_pop_acc   = pop && !w_empty;
  // When full, a same-cycle pop frees the slot this push lands in.
  assign w_push_acc  = push && (!w_full || w_pop_acc);
  assign w_push_lost = push && !w_push_acc;
  assign w_cnt_nxt   = clear ? '0 : r_count + CW'(w_push_acc) - CW'(w_pop_acc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      // Storage is left as-is; count = 0 makes it unreadable.
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_mem[r_wr] <= {push_result, push_negative, push_overflow, push_zero};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop_acc) r_rd <= r_rd + 1'b1;
      r_count <= w_cnt_nxt;
      if (w_push_lost) r_drop <= 1'b1;
    end
  end

`ifdef ALU_FIFO_AFULL_EN
  logic r_afull;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_afull <= 1'b0;
    else       r_afull <= (w_cnt_nxt >= CW'(AFULL_THRESH));
  end
  assign almost_full = r_afull;
`endif

  assign w_head       = w_empty ? '0 : r_mem[r_rd];
  assign pop_result   = w_head[34:3];
  assign pop_negative = w_head[2];
  assign pop_overflow = w_head[1];
  assign pop_zero     = w_head[0];
  assign pop_valid    = !w_empty;
  assign push_ready   = !w_full;
  assign count        = r_count;
  assign drop_err     = r_drop;
endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0] push_result = '0;
  logic        push_negative = 1'b0, push_overflow = 1'b0, push_zero = 1'b0;
  logic        push_ready, pop_valid, pop_negative, pop_overflow, pop_zero, drop_err;
  logic [31:0] pop_result;
  logic [3:0]  count;
`ifdef ALU_FIFO_AFULL_EN
  logic        almost_full;
`endif

  int ntest = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  alu_result_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(6)) dut (
    .CLK(CLK), .nRST(nRST), .clear(clear),
    .push(push), .push_result(push_result), .push_negative(push_negative),
    .push_overflow(push_overflow), .push_zero(push_zero), .push_ready(push_ready),
    .pop(pop), .pop_valid(pop_valid), .pop_result(pop_result),
    .pop_negative(pop_negative), .pop_overflow(pop_overflow), .pop_zero(pop_zero),
    .count(count),
`ifdef ALU_FIFO_AFULL_EN
    .almost_full(almost_full),
`endif
    .drop_err(drop_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: returns 1 time unit after the rising edge, so inputs set
  // afterwards are stable well before the next edge and outputs are settled.
  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic do_push(input logic [31:0] d, input logic n, input logic o, input logic z);
    push = 1'b1; push_result = d; push_negative = n; push_overflow = o; push_zero = z;
    cyc();
    push = 1'b0; push_result = '0; push_negative = 1'b0; push_overflow = 1'b0; push_zero = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1; cyc(); pop = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_pop_result", pop_result, 32'h0);
    nRST = 1'b1;
    cyc();
    chk("idle_count", 32'(count), 0);

    // Two pushes, one-cycle latency, then pop order
    do_push(32'h5, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", 32'(pop_valid), 1);
    chk("lat_result", pop_result, 32'h5);
    do_push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    chk("two_count", 32'(count), 2);
    chk("two_head", pop_result, 32'h5);
    chk("two_head_neg", 32'(pop_negative), 0);
    do_pop();
    chk("pop1_result", pop_result, 32'hFFFF_FFFF);
    chk("pop1_neg", 32'(pop_negative), 1);
    chk("pop1_count", 32'(count), 1);
    do_pop();
    chk("empty_valid", 32'(pop_valid), 0);
    chk("empty_result", pop_result, 32'h0);
    chk("empty_neg", 32'(pop_negative), 0);

    // Pop while empty: ignored
    do_pop();
    chk("popempty_count", 32'(count), 0);
    chk("popempty_drop", 32'(drop_err), 0);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++) do_push(32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 8);
    chk("full_ready", 32'(push_ready), 0);
    chk("full_head", pop_result, 32'h10);
    // 9th push without pop is dropped
    do_push(32'h18, 1'b0, 1'b0, 1'b0);
    chk("drop_err", 32'(drop_err), 1);
    chk("drop_count", 32'(count), 8);
    chk("drop_head", pop_result, 32'h10);
    // Push with pop while full: both accepted, write pointer wraps
    push = 1'b1; push_result = 32'h20; pop = 1'b1;
    cyc();
    push = 1'b0; push_result = '0; pop = 1'b0;
    chk("fullpp_count", 32'(count), 8);
    chk("fullpp_ready", 32'(push_ready), 0);
    chk("fullpp_head", pop_result, 32'h11);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), pop_result, (i == DEPTH-1) ? 32'h20 : 32'h11 + 32'(i));
      do_pop();
    end
    chk("drained_count", 32'(count), 0);
    chk("drop_sticky", 32'(drop_err), 1);

    // Push and pop together while empty: pop ignored
    push = 1'b1; push_result = 32'h7; push_overflow = 1'b1; push_zero = 1'b1; pop = 1'b1;
    cyc();
    push = 1'b0; push_result = '0; push_overflow = 1'b0; push_zero = 1'b0; pop = 1'b0;
    chk("emptypp_count", 32'(count), 1);
    chk("emptypp_result", pop_result, 32'h7);
    chk("emptypp_ovf", 32'(pop_overflow), 1);
    chk("emptypp_zero", 32'(pop_zero), 1);

    // Clear overrides push
    do_push(32'h8, 1'b0, 1'b0, 1'b0);
    do_push(32'h9, 1'b0, 1'b0, 1'b0);
    chk("pre_clear_count", 32'(count), 3);
    clear = 1'b1; push = 1'b1; push_result = 32'hAA;
    cyc();
    clear = 1'b0; push = 1'b0; push_result = '0;
    chk("clr_count", 32'(count), 0);
    chk("clr_valid", 32'(pop_valid), 0);
    chk("clr_drop", 32'(drop_err), 0);
    chk("clr_result", pop_result, 32'h0);
    cyc();
    chk("clr_push_ignored", 32'(count), 0);

`ifdef ALU_FIFO_AFULL_EN
    for (int i = 0; i < 5; i++) do_push(32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("afull_at5", 32'(almost_full), 0);
    do_push(32'h35, 1'b0, 1'b0, 1'b0);
    chk("afull_at6", 32'(almost_full), 1);
    do_pop();
    chk("afull_pop", 32'(almost_full), 0);
    chk("afull_count", 32'(count), 5);
    clear = 1'b1; cyc(); clear = 1'b0;
`endif

    // Asynchronous reset mid-operation
    do_push(32'h40, 1'b0, 1'b0, 1'b0);
    do_push(32'h41, 1'b0, 1'b0, 1'b0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(pop_valid), 0);
    chk("arst_result", pop_result, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
    do_push(32'h55, 1'b1, 1'b0, 1'b0);
    chk("post_rst_result", pop_result, 32'h55);
    chk("post_rst_count", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
